// File: rtl/poly_coef_alu.sv
// poly_coef_alu: coefficient-wise modular ADD / SUB / MUL of two N-coefficient
// polynomials mod Q, LANES coefficients per beat through a two-stage pipeline.
// The run/done handshake matches the NTT wrapper.
// Optional build macro: POLY_ALU_CANON_CHECK_EN. When it is defined, every
// issued operand is compared against Q, and a non-canonical input raises err_o.
module poly_coef_alu #(
  parameter int unsigned N     = 256,
  parameter int unsigned W     = 12,
  parameter int unsigned Q     = 3329,
  parameter int unsigned LANES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [1:0]       mode_i,
  input  logic [N*W-1:0]   poly_a_i,
  input  logic [N*W-1:0]   poly_b_i,
  output logic [N*W-1:0]   poly_c_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - LANES);
  localparam logic [IW-1:0] IDX_STEP = IW'(LANES);

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_MUL = 2'd2;
  localparam logic [1:0] MODE_RSV = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // The modulus is held at the widths each reduction needs. The Barrett
  // constant is floor(2^(2W)/Q), which is valid for any product below 2^(2W).
  localparam longint unsigned QL   = 64'(Q);
  localparam longint unsigned BM_L = (64'd1 << (2 * W)) / QL;
  localparam logic [2*W-1:0]        Q2 = QL[2*W-1:0];
  localparam logic [2*W-1:0]        BM = BM_L[2*W-1:0];
  localparam logic [W:0]            QA = QL[W:0];
  localparam logic signed [W:0]     QS = signed'(QL[W:0]);

  // The sum lies in [0, 2Q-2], so a single conditional subtract makes it canonical.
  function automatic logic [W-1:0] red_add(input logic [W:0] s);
    logic [W:0] r;
    r = (s >= QA) ? s - QA : s;
    return r[W-1:0];
  endfunction

  // The difference lies in [-(Q-1), Q-1], so a single conditional add makes it canonical.
  function automatic logic [W-1:0] red_sub(input logic signed [W:0] d);
    logic signed [W:0] r;
    r = d[W] ? d + QS : d;
    return r[W-1:0];
  endfunction

  // Barrett: the quotient estimate is short by at most one, so the
  // remainder is below 2Q and one subtract reduces it fully.
  function automatic logic [W-1:0] red_mul(input logic [2*W-1:0] p);
    logic [4*W-1:0] t;
    logic [2*W-1:0] q;
    logic [2*W-1:0] r;
    t = {{(2*W){1'b0}}, p} * {{(2*W){1'b0}}, BM};
    q = t[4*W-1:2*W];
    r = p - q * Q2;
    if (r >= Q2) r = r - Q2;
    return r[W-1:0];
  endfunction

  // Raw stage-1 value. SUB keeps its W+1-bit two's-complement pattern in the low bits.
  function automatic logic [2*W-1:0] stage1_raw(input logic [1:0] m,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    logic [W:0]          s;
    logic signed [W:0]   d;
    logic [2*W-1:0]      p;
    s = {1'b0, a} + {1'b0, b};
    d = signed'({1'b0, a}) - signed'({1'b0, b});
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (m)
      MODE_ADD: return {{(W-1){1'b0}}, s};
      MODE_SUB: return {{(W-1){1'b0}}, d};
      default:  return p;
    endcase
  endfunction

  // Final reduction selected by the latched mode.
  function automatic logic [W-1:0] stage2_red(input logic [1:0] m,
                                              input logic [2*W-1:0] raw);
    case (m)
      MODE_ADD: return red_add(raw[W:0]);
      MODE_SUB: return red_sub(signed'(raw[W:0]));
      default:  return red_mul(raw);
    endcase
  endfunction

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [1:0]    mode_q;

  logic [W-1:0]  a_arr [N];
  logic [W-1:0]  b_arr [N];
  logic [W-1:0]  c_arr [N];

  logic [2*W-1:0] raw_p0 [LANES];
  logic [2*W-1:0] raw_p1 [LANES];
  logic [IW-1:0]  idx_p1;
  logic           vld_p1;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign a_arr[g] = poly_a_i[g*W +: W];
    assign b_arr[g] = poly_b_i[g*W +: W];
    assign poly_c_o[g*W +: W] = c_arr[g];
  end

  assign busy_o = (state == S_ISSUE) || (state == S_DRAIN);
  assign done_o = (state == S_DONE);

`ifdef POLY_ALU_CANON_CHECK_EN
  logic bad_p0;

  // Flag any issued operand that is not below Q.
  always_comb begin
    bad_p0 = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if ({1'b0, a_arr[idx + IW'(l)]} >= QA || {1'b0, b_arr[idx + IW'(l)]} >= QA)
        bad_p0 = 1'b1;
    end
  end
`endif

  // Control FSM: accept a run, step the beat index, drain, then pulse done.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_IDLE;
      idx    <= '0;
      mode_q <= MODE_ADD;
      err_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run_i) begin
            mode_q <= mode_i;
            idx    <= '0;
            if (mode_i == MODE_RSV) begin
              state <= S_DONE;
              err_o <= 1'b1;
            end else begin
              state <= S_ISSUE;
              err_o <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          idx <= idx + IDX_STEP;
          if (idx == IDX_LAST) state <= S_DRAIN;
`ifdef POLY_ALU_CANON_CHECK_EN
          if (bad_p0) err_o <= 1'b1;
`endif
        end
        S_DRAIN: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 0 -> 1: lane operands are read at idx and raw results are formed.
  always_comb begin
    for (int l = 0; l < LANES; l++)
      raw_p0[l] = stage1_raw(mode_q, a_arr[idx + IW'(l)], b_arr[idx + IW'(l)]);
  end

  // Stage 1 valid follows the ISSUE beats.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) vld_p1 <= 1'b0;
    else       vld_p1 <= (state == S_ISSUE);
  end

  // Stage 1 data registers, with no reset because vld_p1 qualifies them.
  always_ff @(posedge clk_i) begin
    idx_p1 <= idx;
    raw_p1 <= raw_p0;
  end

  // Stage 1 -> 2: the final reduction writes its lanes into the result register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < N; n++) c_arr[n] <= '0;
    end else if (vld_p1) begin
      for (int l = 0; l < LANES; l++)
        c_arr[idx_p1 + IW'(l)] <= stage2_red(mode_q, raw_p1[l]);
    end
  end

endmodule
